// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: load/store request -> req/ack bus transaction, load extension, dmem_stall.
// Latency: 2 stall cycles + 1 DONE cycle minimum; DONE result is held while imem_stall is high.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        imem_stall,
    output logic [31:0] rdata,
    output logic        dmem_stall,
    output logic        dmem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    acc_size_t   size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    logic        req;
    acc_size_t   req_size;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;

    // Encodings 100/101 only exist for loads; as stores they fall back to word.
    always_comb begin
        req      = mem_rd | mem_wr;
        req_size = SZ_WORD;
        case (funct3)
            3'b000:  req_size = SZ_BYTE;
            3'b001:  req_size = SZ_HALF;
            3'b100:  req_size = mem_wr ? SZ_WORD : SZ_BYTE;
            3'b101:  req_size = mem_wr ? SZ_WORD : SZ_HALF;
            default: req_size = SZ_WORD;
        endcase

        misaligned = 1'b0;
        case (req_size)
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        lane_be    = 4'hF;
        lane_wdata = wdata;
        if (mem_wr) begin
            case (req_size)
                SZ_BYTE: begin
                    lane_be    = 4'b0001 << addr[1:0];
                    lane_wdata = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    lane_be    = 4'hF;
                    lane_wdata = wdata;
                end
            endcase
        end
    end

    // Load extension uses the lane/size latched at launch, not the live pipeline inputs.
    always_comb begin
        byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wdata_d = lane_wdata;
                        bus_be_d    = lane_be;
                        cnt_d       = '0;
                        size_d      = req_size;
                        uns_d       = funct3[2];
                        off_d       = addr[1:0];
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Ack is checked first so a last-cycle ack beats the timeout.
                if (bus_ack) begin
                    rdata_d   = bus_we_q ? 32'h0 : ld_ext;
                    err_d     = 1'b0;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (!imem_stall) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_IDLE: dmem_stall = req;
            ST_REQ:  dmem_stall = 1'b1;
            default: dmem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            off_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign rdata     = rdata_q;
    assign dmem_err  = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule
